// File: rtl/hbm_bench_pkg.sv
// Shared AXI encodings and state type for the HBM benchmark traffic engines.
package hbm_bench_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_32B   = 3'd5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } rd_state_t;

endpackage

// File: rtl/hbm_rd_engine.sv
// AXI3 read-traffic master: issues strided read bursts, drains every R beat and
// accumulates run statistics for one HBM pseudo-channel.
module hbm_rd_engine
    import hbm_bench_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 33,
    parameter int unsigned DATA_WIDTH      = 256,
    parameter int unsigned ID_WIDTH        = 6,
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [31:0]           cfg_stride,
    input  logic [ADDR_WIDTH-1:0] cfg_addr_mask,
    input  logic [31:0]           cfg_num_ops,
    input  logic [3:0]            cfg_burst_len,
    output logic                  busy,
    output logic                  done,
    output logic [63:0]           stat_cycles,
    output logic [31:0]           stat_beats,
    output logic [31:0]           stat_first_lat,
    output logic [31:0]           stat_resp_err,
    output logic                  stat_len_err,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [3:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [ID_WIDTH-1:0]   arid,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [ID_WIDTH-1:0]   rid,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int unsigned     OutW   = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OutW-1:0] MaxOut = OutW'(MAX_OUTSTANDING);

    rd_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           stride_q, stride_d;
    logic [ADDR_WIDTH-1:0] mask_q, mask_d;
    logic [31:0]           num_ops_q, num_ops_d;
    logic [3:0]            len_q, len_d;
    logic [ADDR_WIDTH-1:0] offset_q, offset_d;
    logic [31:0]           issued_q, issued_d;
    logic [OutW-1:0]       outstanding_q, outstanding_d;
    logic [3:0]            beat_cnt_q, beat_cnt_d;
    logic                  first_ar_q, first_ar_d;
    logic                  lat_run_q, lat_run_d;
    logic [63:0]           cycles_q, cycles_d;
    logic [31:0]           beats_q, beats_d;
    logic [31:0]           first_lat_q, first_lat_d;
    logic [31:0]           resp_err_q, resp_err_d;
    logic                  len_err_q, len_err_d;

    logic ar_hs;
    logic r_hs;
    logic run;

    // Read payload is only counted, never inspected.
    logic unused_rd;
    assign unused_rd = ^{rdata, rid};

    assign run     = (state_q == StRun);
    assign arvalid = run && (issued_q < num_ops_q) && (outstanding_q < MaxOut);
    assign araddr  = run ? base_q + (offset_q & mask_q) : '0;
    assign arlen   = run ? len_q : 4'd0;
    assign arsize  = run ? AXI_SIZE_32B : 3'd0;
    assign arburst = run ? AXI_BURST_INCR : 2'd0;
    assign arid    = '0;
    assign rready  = run;
    assign busy    = run;
    assign done    = (state_q == StDone);

    assign ar_hs = arvalid && arready;
    assign r_hs  = rready && rvalid;

    assign stat_cycles    = cycles_q;
    assign stat_beats     = beats_q;
    assign stat_first_lat = first_lat_q;
    assign stat_resp_err  = resp_err_q;
    assign stat_len_err   = len_err_q;

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        stride_d      = stride_q;
        mask_d        = mask_q;
        num_ops_d     = num_ops_q;
        len_d         = len_q;
        offset_d      = offset_q;
        issued_d      = issued_q;
        outstanding_d = outstanding_q;
        beat_cnt_d    = beat_cnt_q;
        first_ar_d    = first_ar_q;
        lat_run_d     = lat_run_q;
        cycles_d      = cycles_q;
        beats_d       = beats_q;
        first_lat_d   = first_lat_q;
        resp_err_d    = resp_err_q;
        len_err_d     = len_err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d        = cfg_base_addr;
                    stride_d      = cfg_stride;
                    mask_d        = cfg_addr_mask;
                    num_ops_d     = cfg_num_ops;
                    len_d         = cfg_burst_len;
                    offset_d      = '0;
                    issued_d      = '0;
                    outstanding_d = '0;
                    beat_cnt_d    = '0;
                    first_ar_d    = 1'b0;
                    lat_run_d     = 1'b0;
                    cycles_d      = '0;
                    beats_d       = '0;
                    first_lat_d   = '0;
                    resp_err_d    = '0;
                    len_err_d     = 1'b0;
                    state_d       = StRun;
                end
            end
            StRun: begin
                cycles_d = cycles_q + 64'd1;
                if (ar_hs) begin
                    issued_d = issued_q + 32'd1;
                    offset_d = offset_q + ADDR_WIDTH'(stride_q);
                    if (!first_ar_q) begin
                        first_ar_d = 1'b1;
                        lat_run_d  = 1'b1;
                    end
                end
                // Latency counts the cycles after the first AR up to and including the first R.
                if (lat_run_q) begin
                    first_lat_d = first_lat_q + 32'd1;
                    if (r_hs) begin
                        lat_run_d = 1'b0;
                    end
                end
                if (r_hs) begin
                    beats_d    = beats_q + 32'd1;
                    beat_cnt_d = rlast ? 4'd0 : beat_cnt_q + 4'd1;
                    if (rresp != 2'b00) begin
                        resp_err_d = resp_err_q + 32'd1;
                    end
                    if (rlast != (beat_cnt_q == len_q)) begin
                        len_err_d = 1'b1;
                    end
                end
                if (ar_hs && !(r_hs && rlast)) begin
                    outstanding_d = outstanding_q + OutW'(1);
                end else if (!ar_hs && r_hs && rlast && (outstanding_q != '0)) begin
                    outstanding_d = outstanding_q - OutW'(1);
                end
                if ((issued_q == num_ops_q) && (outstanding_q == '0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q       <= StIdle;
            base_q        <= '0;
            stride_q      <= '0;
            mask_q        <= '0;
            num_ops_q     <= '0;
            len_q         <= '0;
            offset_q      <= '0;
            issued_q      <= '0;
            outstanding_q <= '0;
            beat_cnt_q    <= '0;
            first_ar_q    <= 1'b0;
            lat_run_q     <= 1'b0;
            cycles_q      <= '0;
            beats_q       <= '0;
            first_lat_q   <= '0;
            resp_err_q    <= '0;
            len_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            stride_q      <= stride_d;
            mask_q        <= mask_d;
            num_ops_q     <= num_ops_d;
            len_q         <= len_d;
            offset_q      <= offset_d;
            issued_q      <= issued_d;
            outstanding_q <= outstanding_d;
            beat_cnt_q    <= beat_cnt_d;
            first_ar_q    <= first_ar_d;
            lat_run_q     <= lat_run_d;
            cycles_q      <= cycles_d;
            beats_q       <= beats_d;
            first_lat_q   <= first_lat_d;
            resp_err_q    <= resp_err_d;
            len_err_q     <= len_err_d;
        end
    end

endmodule

// File: tb/tb_hbm_rd_engine.sv
// Bench for hbm_rd_engine: scoreboarded AR addresses, a latency-configurable
// read memory model on the R channel, and directed runs checking the statistics.
`timescale 1ns/1ps
module tb_hbm_rd_engine;

    localparam int AW = 33;
    localparam int DW = 256;
    localparam int IW = 6;
    localparam int MO = 16;

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [31:0]   cfg_stride = '0;
    logic [AW-1:0] cfg_addr_mask = '0;
    logic [31:0]   cfg_num_ops = '0;
    logic [3:0]    cfg_burst_len = '0;
    logic          busy;
    logic          done;
    logic [63:0]   stat_cycles;
    logic [31:0]   stat_beats;
    logic [31:0]   stat_first_lat;
    logic [31:0]   stat_resp_err;
    logic          stat_len_err;
    logic [AW-1:0] araddr;
    logic [3:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [IW-1:0] arid;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic [IW-1:0] rid = '0;
    logic [1:0]    rresp = '0;
    logic          rlast = 1'b0;
    logic          rvalid = 1'b0;
    logic          rready;

    hbm_rd_engine #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .ID_WIDTH        (IW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk            (clk),
        .arstn          (arstn),
        .start          (start),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_stride     (cfg_stride),
        .cfg_addr_mask  (cfg_addr_mask),
        .cfg_num_ops    (cfg_num_ops),
        .cfg_burst_len  (cfg_burst_len),
        .busy           (busy),
        .done           (done),
        .stat_cycles    (stat_cycles),
        .stat_beats     (stat_beats),
        .stat_first_lat (stat_first_lat),
        .stat_resp_err  (stat_resp_err),
        .stat_len_err   (stat_len_err),
        .araddr         (araddr),
        .arlen          (arlen),
        .arsize         (arsize),
        .arburst        (arburst),
        .arid           (arid),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rid            (rid),
        .rresp          (rresp),
        .rlast          (rlast),
        .rvalid         (rvalid),
        .rready         (rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rdy;
        int len;
        int op;
    } burst_t;

    burst_t        mem_q[$];
    logic [AW-1:0] exp_addr_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mem_lat = 1;
    int exp_len = 0;
    int trunc_op = -1;
    int trunc_beat = 0;
    int err_beats_left = 0;
    int ar_cnt = 0;
    int tb_out = 0;
    int max_out = 0;
    int beats_seen = 0;
    int beat_idx = 0;
    bit ar_random = 1'b0;
    bit stall_q = 1'b0;
    logic [AW-1:0] stall_addr = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory model: samples AR handshakes and returns bursts in order after mem_lat cycles.
    initial begin : responder
        forever begin
            @(negedge clk);
            cyc++;
            if (!arstn) begin
                mem_q.delete();
                rvalid   = 1'b0;
                rlast    = 1'b0;
                rresp    = 2'b00;
                arready  = 1'b0;
                beat_idx = 0;
                stall_q  = 1'b0;
            end else begin
                if (stall_q) begin
                    check("ar_hold_valid", arvalid, 1);
                    check("ar_hold_addr", araddr, stall_addr);
                end
                arready = ar_random ? 1'($urandom_range(0, 1)) : 1'b1;
                stall_q = arvalid && !arready;
                stall_addr = araddr;
                if (arvalid && arready) begin
                    if (exp_addr_q.size() == 0) begin
                        check("ar_unexpected", arvalid, 0);
                    end else begin
                        check("araddr", araddr, exp_addr_q.pop_front());
                    end
                    check("arlen", arlen, exp_len);
                    check("arsize", arsize, 5);
                    check("arburst", arburst, 1);
                    check("arid", arid, 0);
                    mem_q.push_back('{rdy: cyc + mem_lat, len: int'(arlen), op: ar_cnt});
                    ar_cnt++;
                    tb_out++;
                end
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
                if (mem_q.size() > 0 && mem_q[0].rdy <= cyc) begin
                    rvalid = 1'b1;
                    rlast  = (beat_idx == mem_q[0].len) ||
                             (mem_q[0].op == trunc_op && beat_idx == trunc_beat);
                    rresp  = (err_beats_left > 0) ? 2'd2 : 2'd0;
                    rdata  = {8{$urandom()}};
                    if (rready) begin
                        beats_seen++;
                        if (err_beats_left > 0) err_beats_left--;
                        if (rlast) begin
                            void'(mem_q.pop_front());
                            beat_idx = 0;
                            tb_out--;
                        end else begin
                            beat_idx++;
                        end
                    end
                end
                if (tb_out > max_out) max_out = tb_out;
            end
        end
    end

    task automatic launch(input logic [AW-1:0] base, input logic [31:0] stride,
                          input logic [AW-1:0] mask, input int nops, input int len,
                          input int lat, input int tr_op, input int tr_beat, input int err_n);
        logic [63:0] full;
        mem_lat        = lat;
        exp_len        = len;
        trunc_op       = tr_op;
        trunc_beat     = tr_beat;
        err_beats_left = err_n;
        ar_cnt         = 0;
        tb_out         = 0;
        max_out        = 0;
        beats_seen     = 0;
        exp_addr_q.delete();
        for (int i = 0; i < nops; i++) begin
            full = 64'(i) * 64'(stride);
            exp_addr_q.push_back(AW'(64'(base) + (full & 64'(mask))));
        end
        cfg_base_addr = base;
        cfg_stride    = stride;
        cfg_addr_mask = mask;
        cfg_num_ops   = 32'(nops);
        cfg_burst_len = 4'(len);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble the inputs: the run must use the latched copy.
        cfg_base_addr = '1;
        cfg_stride    = 32'h1234;
        cfg_addr_mask = '0;
        cfg_num_ops   = 32'd3;
        cfg_burst_len = 4'hF;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int budget, output int done_cnt);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        done_cnt = 0;
        while (!seen && n < budget) begin
            if (done) begin
                seen = 1'b1;
                done_cnt++;
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("done_seen", seen, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("idle_after_done", busy, 0);
        check("all_ar_issued", exp_addr_q.size(), 0);
        check("tb_beats_vs_stat", stat_beats, beats_seen);
    endtask

    initial begin : main
        int dc;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_araddr", araddr, 0);
        check("rst_stat_cycles", stat_cycles, 0);
        arstn = 1'b1;
        @(posedge clk);
        #1;

        // Basic strided run, single-beat bursts, one-cycle memory.
        launch(33'h1000, 32'h40, '1, 4, 0, 1, -1, 0, 0);
        wait_done(200, dc);
        check("t1_done_once", dc, 1);
        check("t1_beats", stat_beats, 4);
        check("t1_resp_err", stat_resp_err, 0);
        check("t1_len_err", stat_len_err, 0);

        // Masked offset wrap with random arready stalls.
        ar_random = 1'b1;
        launch(33'h2000, 32'h40, 33'hFF, 8, 1, 3, -1, 0, 0);
        wait_done(400, dc);
        ar_random = 1'b0;
        check("t2_done_once", dc, 1);
        check("t2_beats", stat_beats, 16);
        check("t2_len_err", stat_len_err, 0);

        // Long latency: outstanding limit, first-access latency.
        launch(33'h0, 32'h200, '1, 32, 15, 100, -1, 0, 0);
        wait_done(3000, dc);
        check("t3_max_outstanding", max_out, 16);
        check("t3_beats", stat_beats, 512);
        check("t3_first_lat", stat_first_lat, 100);
        check("t3_len_err", stat_len_err, 0);

        // Early rlast on op 1 beat 3, error response on the first 5 beats.
        launch(33'h4000, 32'h100, '1, 4, 7, 2, 1, 3, 5);
        wait_done(400, dc);
        check("t4_beats", stat_beats, 28);
        check("t4_len_err", stat_len_err, 1);
        check("t4_resp_err", stat_resp_err, 5);

        // Zero operations: one RUN cycle, no AR.
        launch(33'h8000, 32'h40, '1, 0, 0, 1, -1, 0, 0);
        check("t5_no_arvalid_c1", arvalid, 0);
        @(posedge clk);
        #1;
        check("t5_done", done, 1);
        check("t5_cycles", stat_cycles, 1);
        check("t5_no_arvalid_c2", arvalid, 0);
        @(posedge clk);
        #1;
        check("t5_done_pulse", done, 0);
        check("t5_ar_count", ar_cnt, 0);

        // Reset with five bursts in flight, then a clean rerun.
        launch(33'h0, 32'h200, '1, 32, 15, 100, -1, 0, 0);
        n = 0;
        while (ar_cnt < 5 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_five_in_flight", tb_out, 5);
        arstn = 1'b0;
        @(posedge clk);
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_arvalid", arvalid, 0);
        check("t6_rst_rready", rready, 0);
        check("t6_rst_cycles", stat_cycles, 0);
        check("t6_rst_first_lat", stat_first_lat, 0);
        check("t6_rst_beats", stat_beats, 0);
        arstn = 1'b1;
        exp_addr_q.delete();
        @(posedge clk);
        #1;
        launch(33'h1000, 32'h40, '1, 4, 0, 1, -1, 0, 0);
        wait_done(200, dc);
        check("t6_rerun_done_once", dc, 1);
        check("t6_rerun_beats", stat_beats, 4);
        check("t6_rerun_len_err", stat_len_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog observed=timeout required=finish checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
